// File: rtl/fifo_sync_flags_if.sv
// Handshake/status bundle between a FIFO and its producer/consumer.
// master: the client side (drives WR/RD/dataIn/flush/clr_err, observes status).
// slave : the FIFO side (observes requests, drives dataOut/count/flags).
interface fifo_sync_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 3
);
  logic                  flush;
  logic                  clr_err;
  logic                  WR;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  RD;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, WR, dataIn, RD,
    input  dataOut, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, WR, dataIn, RD,
    output dataOut, full, almost_full, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// Ports:
//   clk   - clock, all logic on posedge
//   rstn  - synchronous active-low reset (clears pointers, count, dataOut, errors)
//   bus   - fifo_sync_flags_if.slave: WR/dataIn, RD/dataOut, flush, clr_err,
//           full, almost_full, empty, almost_empty, count, overflow, underflow
// Build option: FIFO_FWFT_EN selects first-word fall-through (dataOut shows the
// head word combinationally); otherwise dataOut is registered one cycle after RD.
module fifo_sync_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 5,
  parameter int unsigned AF_THRESH  = DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rstn,
  fifo_sync_flags_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic full_c, empty_c, rd_acc_c, wr_acc_c;

  // Pointer increment with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Status flags decode only the registered count.
  assign full_c           = (count_q == FULL_CNT);
  assign empty_c          = (count_q == '0);
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (32'(count_q) >= AF_THRESH);
  assign bus.almost_empty = (32'(count_q) <= AE_THRESH);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // A read frees a slot, so a write into a full FIFO passes through.
  assign rd_acc_c = bus.RD & ~empty_c;
  assign wr_acc_c = bus.WR & (~full_c | rd_acc_c);

  // Next-state for pointers, count and sticky errors; flush overrides requests.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc_c) rd_ptr_d = ptr_inc(rd_ptr_q);

      case ({wr_acc_c, rd_acc_c})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase

      // Clear first so a same-cycle error event keeps the flag set.
      if (bus.clr_err) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end
      if (bus.WR & ~wr_acc_c) overflow_d  = 1'b1;
      if (bus.RD & ~rd_acc_c) underflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (rstn && !bus.flush && wr_acc_c) begin
      mem_q[wr_ptr_q] <= bus.dataIn;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always visible; a pop exposes the next one after the edge.
  assign bus.dataOut = mem_q[rd_ptr_q];
`else
  logic [DATA_WIDTH-1:0] dataout_q;

  // Registered read port, holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dataout_q <= '0;
    end else if (!bus.flush && rd_acc_c) begin
      dataout_q <= mem_q[rd_ptr_q];
    end
  end

  assign bus.dataOut = dataout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags (DEPTH=5, AF_THRESH=3, AE_THRESH=1).
module tb_fifo_sync_flags;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fifo_sync_flags #(
    .DATA_WIDTH (DW),
    .DEPTH      (5),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.WR     = 1'b1;
    bus.dataIn = d;
    step();
    bus.WR     = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
`ifdef FIFO_FWFT_EN
    chk(tag, 32'(bus.dataOut), 32'(exp));
    bus.RD = 1'b1;
    step();
    bus.RD = 1'b0;
`else
    bus.RD = 1'b1;
    step();
    bus.RD = 1'b0;
    chk(tag, 32'(bus.dataOut), 32'(exp));
`endif
  endtask

  initial begin
    logic [DW-1:0] wv;
    logic [DW-1:0] rv;
    n_chk = 0;
    n_err = 0;
    rstn        = 1'b0;
    bus.WR      = 1'b0;
    bus.RD      = 1'b0;
    bus.dataIn  = '0;
    bus.flush   = 1'b0;
    bus.clr_err = 1'b0;
    step();
    step();
    rstn = 1'b1;

    // Reset state
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ae", 32'(bus.almost_empty), 1);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", 32'(bus.dataOut), 0);
`endif

    // 1. Fill and drain
    for (int i = 0; i < 5; i++) push(DW'(8'h10 + i));
    chk("t1_count", 32'(bus.count), 5);
    chk("t1_full", 32'(bus.full), 1);
    chk("t1_af", 32'(bus.almost_full), 1);
    for (int i = 0; i < 5; i++) pop_chk("t1_rd", DW'(8'h10 + i));
    chk("t1_empty", 32'(bus.empty), 1);

    // 2. Wrap across the non-power-of-two boundary
    wv = 8'h00;
    rv = 8'h00;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        push(wv);
        wv = wv + 8'd1;
      end
      for (int j = 0; j < 3; j++) begin
        pop_chk("t2_rd", rv);
        rv = rv + 8'd1;
      end
    end
    chk("t2_count", 32'(bus.count), 0);

    // 3. Pass-through while full
    for (int i = 0; i < 5; i++) push(DW'(8'hA0 + i));
`ifdef FIFO_FWFT_EN
    chk("t3_head", 32'(bus.dataOut), 32'h A0);
`endif
    bus.WR     = 1'b1;
    bus.dataIn = 8'hB0;
    bus.RD     = 1'b1;
    step();
    bus.WR = 1'b0;
    bus.RD = 1'b0;
    chk("t3_count", 32'(bus.count), 5);
    chk("t3_ovf", 32'(bus.overflow), 0);
`ifndef FIFO_FWFT_EN
    chk("t3_dout", 32'(bus.dataOut), 32'h A0);
`endif
    for (int i = 1; i < 5; i++) pop_chk("t3_rd", DW'(8'hA0 + i));
    pop_chk("t3_rd_b0", 8'hB0);

    // 4. Sticky errors
    for (int i = 0; i < 5; i++) push(DW'(8'hC0 + i));
    push(8'hEE);
    chk("t4_ovf", 32'(bus.overflow), 1);
    chk("t4_cnt_full", 32'(bus.count), 5);
    for (int i = 0; i < 5; i++) pop_chk("t4_rd", DW'(8'hC0 + i));
    chk("t4_empty", 32'(bus.empty), 1);
    bus.RD = 1'b1;
    step();
    bus.RD = 1'b0;
    chk("t4_unf", 32'(bus.underflow), 1);
`ifndef FIFO_FWFT_EN
    chk("t4_dout_hold", 32'(bus.dataOut), 32'h C4);
`endif
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("t4_clr_ovf", 32'(bus.overflow), 0);
    chk("t4_clr_unf", 32'(bus.underflow), 0);
    for (int i = 0; i < 5; i++) push(DW'(8'hD0 + i));
    bus.clr_err = 1'b1;
    bus.WR      = 1'b1;
    bus.dataIn  = 8'hEF;
    step();
    bus.clr_err = 1'b0;
    bus.WR      = 1'b0;
    chk("t4_clr_vs_ovf", 32'(bus.overflow), 1);
    chk("t4_clr_unf2", 32'(bus.underflow), 0);

    // 5. Flush (overflow stays set), then reset mid-stream
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t5_flush0_count", 32'(bus.count), 0);
    for (int i = 0; i < 3; i++) push(DW'(8'h30 + i));
    chk("t5_count3", 32'(bus.count), 3);
    bus.flush  = 1'b1;
    bus.WR     = 1'b1;
    bus.dataIn = 8'h99;
    step();
    bus.flush = 1'b0;
    bus.WR    = 1'b0;
    chk("t5_flush_count", 32'(bus.count), 0);
    chk("t5_flush_empty", 32'(bus.empty), 1);
    chk("t5_flush_ovf", 32'(bus.overflow), 1);
    push(8'h41);
    push(8'h42);
    pop_chk("t5_rd", 8'h41);
    rstn       = 1'b0;
    bus.WR     = 1'b1;
    bus.dataIn = 8'h43;
    step();
    rstn   = 1'b1;
    bus.WR = 1'b0;
    chk("t5_rst_count", 32'(bus.count), 0);
    chk("t5_rst_empty", 32'(bus.empty), 1);
    chk("t5_rst_ovf", 32'(bus.overflow), 0);
    chk("t5_rst_af", 32'(bus.almost_full), 0);
`ifndef FIFO_FWFT_EN
    chk("t5_rst_dout", 32'(bus.dataOut), 0);
`endif

    // 6. Thresholds and head visibility
    push(8'h55);
    chk("t6_ae_c1", 32'(bus.almost_empty), 1);
    chk("t6_af_c1", 32'(bus.almost_full), 0);
`ifdef FIFO_FWFT_EN
    chk("t6_fwft_head", 32'(bus.dataOut), 32'h55);
`else
    chk("t6_dout_no_rd", 32'(bus.dataOut), 0);
`endif
    push(8'h56);
    chk("t6_ae_c2", 32'(bus.almost_empty), 0);
    chk("t6_af_c2", 32'(bus.almost_full), 0);
    push(8'h57);
    chk("t6_af_c3", 32'(bus.almost_full), 1);
    chk("t6_full_c3", 32'(bus.full), 0);
    pop_chk("t6_rd", 8'h55);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock FIFO, the successor to the grayscale pipeline's fixed 4-entry buffer. Supports arbitrary (non-power-of-two) depth and any data width. Adds an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a synchronous flush. Sits between pixel producers and consumers in the grayscale datapath, for example as a line or pixel buffer.

Parameters:
DATA_WIDTH, 8, width of each entry in bits
DEPTH, 5, number of entries; any value >= 2, not restricted to a power of two
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH
PTR_WIDTH, $clog2(DEPTH), width of the read and write pointers
CNT_WIDTH, $clog2(DEPTH+1), width of count

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  reset, synchronous, active-low
flush  in  1  synchronous empty request
clr_err  in  1  clears the sticky overflow and underflow flags
WR  in  1  write request
dataIn  in  DATA_WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
RD  in  1  read request
dataOut  out  DATA_WIDTH  read data
empty  out  1  count == 0
almost_empty  out  1  count <= AE_THRESH
count  out  CNT_WIDTH  current occupancy
overflow  out  1  sticky; set by a rejected write
underflow  out  1  sticky; set by a rejected read

Behaviour:
- Reset: rstn synchronous, active-low, clock clk. While rstn=0 at a posedge:
  - wr_ptr, rd_ptr, count, dataOut, overflow and underflow all go to 0.
  - Memory contents are not reset.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
  - Reset asserted mid-stream discards all contents in the same cycle.
- Status flags are combinational decodes of the registered count only. They never depend on WR or RD in the same cycle.
- Write accept: wr_acc = WR & (~full | rd_acc).
  - Pass-through when full: a simultaneous accepted read frees a slot, so the write is also accepted.
  - On accept: MEM[wr_ptr] <= dataIn.
- Read accept: rd_acc = RD & ~empty.
  - A read while empty is rejected, even if WR is high in the same cycle.
- Pointer wrap: a pointer advances by 1 on accept. At DEPTH-1 it wraps to 0, which supports non-power-of-two DEPTH.
- Count update per cycle:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted, or when neither is.
- Error flags:
  - overflow <= 1 when WR & ~wr_acc.
  - underflow <= 1 when RD & ~rd_acc.
  - clr_err clears both. A new error event in the same cycle as clr_err wins, so the flag stays 1.
- Read latency (standard mode): dataOut <= MEM[rd_ptr] on rd_acc, valid the cycle after the request. dataOut holds its value otherwise.
- Flush:
  - When flush=1: wr_ptr, rd_ptr and count go to 0. WR and RD are ignored that cycle, with no memory write and no error set.
  - dataOut and the error flags are unchanged.
  - Priority: rstn > flush > WR/RD.
- Data ordering is strictly first-in first-out, including across pointer wrap and pass-through cycles.

Optional Feature:
FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - dataOut = MEM[rd_ptr] combinationally whenever ~empty, so the head word is visible with no RD.
  - rd_acc pops the head, and the next word appears after the posedge.
  - dataOut is don't-care while empty. The bench checks it only when ~empty.
- Undefined: the registered one-cycle read latency above applies, and dataOut resets to 0.
- Flags, count, errors and flush behave identically in both modes.

Test Plan:
1. Fill and drain, DEPTH=5: write 0x10..0x14 -> count 5, full=1, almost_full=1. Read 5 times -> dataOut 0x10..0x14 in order, empty=1.
2. Wrap, non-power-of-two: 8 cycles of write-3/read-3 interleaved, pushing 0x00..0x17 -> pointers wrap 4->0, all 24 values read back in order, count returns to 0.
3. Full pass-through: with the FIFO full (0xA0..0xA4), assert WR=1 dataIn=0xB0 and RD=1 -> count stays 5, overflow=0, dataOut=0xA0. Five later reads return 0xA1..0xA4, 0xB0.
4. Errors: WR while full -> overflow=1, contents unchanged. RD while empty -> underflow=1, dataOut unchanged. clr_err for 1 cycle -> both flags 0. clr_err together with a rejected WR -> overflow stays 1.
5. Flush and reset: with count 3, flush=1 and WR=1 -> count 0, empty=1, no write. rstn=0 mid-stream -> all outputs at reset values on the next cycle.
6. Thresholds with AF_THRESH=3, AE_THRESH=1: count 1 -> almost_empty=1; count 2 -> almost_empty=0, almost_full=0; count 3 -> almost_full=1. With FIFO_FWFT_EN, after writing 0x55, dataOut=0x55 with no RD.
